// File: rtl/fuzzy_risk_seq.sv
// Fuzzy rainfall/soil-moisture risk estimator: triangular fuzzify, min() rules, weighted-average defuzzify.
// Latency 3+NUMW cycles from accept (3 when no rule fires); single transaction in flight, held in DONE until out_ready.
module fuzzy_risk_seq #(
  parameter int W      = 8,
  parameter int GW     = 8,
  parameter int OW     = 8,
  parameter int C_LO   = 20,
  parameter int C_MD   = 50,
  parameter int C_HI   = 80,
  parameter int HW     = 20,
  parameter int OUT_LO = 85,
  parameter int OUT_MD = 170,
  parameter int OUT_HI = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  rain,
  input  logic [W-1:0]  soil,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] risk,
  output logic          no_fire,
  output logic          busy
);

  localparam int GMAX = (1 << GW) - 1;
  localparam int NUMW = GW + OW + 2;
  localparam int DW   = GW + 2;
  localparam int PW   = W + GW;
  localparam int CW   = $clog2(NUMW);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FUZZ = 3'd1,
    RULE = 3'd2,
    SUM  = 3'd3,
    DIV  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]    rain_q, soil_q;
  logic [GW-1:0]   rain_lo_q, rain_md_q, rain_hi_q;
  logic [GW-1:0]   soil_lo_q, soil_md_q, soil_hi_q;
  logic [GW-1:0]   s_lo_q, s_md_q, s_hi_q;
  logic [NUMW-1:0] quo_q;
  logic [DW-1:0]   den_q;
  logic [DW-1:0]   rem_q;
  logic [CW-1:0]   cnt_q;
  logic [OW-1:0]   risk_q;
  logic            no_fire_q;

  logic            accept;
  logic [NUMW-1:0] num_c;
  logic [DW-1:0]   den_c;
  logic [DW:0]     rem_sh;
  logic            q_bit;
  logic [DW-1:0]   rem_n;
  logic [NUMW-1:0] quo_n;

  // Range is checked before any subtraction so samples outside [a, c] never wrap.
  function automatic logic [GW-1:0] grade(input logic [W-1:0] x, input int ctr);
    logic [W-1:0]  a, c, m, d;
    logic [PW-1:0] p;
    a = W'(ctr - HW);
    c = W'(ctr + HW);
    m = W'(ctr);
    d = '0;
    p = '0;
    grade = '0;
    if (x > a && x < c) begin
      d = (x <= m) ? (x - a) : (c - x);
      p = PW'(d) * PW'(GMAX);
      grade = GW'(p / PW'(HW));
    end
  endfunction

  function automatic logic [GW-1:0] min2(input logic [GW-1:0] a, input logic [GW-1:0] b);
    min2 = (a < b) ? a : b;
  endfunction

  assign in_ready  = en && (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign risk      = risk_q;
  assign no_fire   = no_fire_q;

  assign num_c = NUMW'(s_hi_q) * NUMW'(OUT_HI)
               + NUMW'(s_md_q) * NUMW'(OUT_MD)
               + NUMW'(s_lo_q) * NUMW'(OUT_LO);
  assign den_c = DW'(s_hi_q) + DW'(s_md_q) + DW'(s_lo_q);

  // Restoring step: remainder stays below den, so the shifted value needs one extra bit.
  always_comb begin
    rem_sh = {rem_q, quo_q[NUMW-1]};
    q_bit  = (rem_sh >= {1'b0, den_q});
    rem_n  = q_bit ? DW'(rem_sh - {1'b0, den_q}) : rem_sh[DW-1:0];
    quo_n  = {quo_q[NUMW-2:0], q_bit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FUZZ;
      FUZZ:    state_d = RULE;
      RULE:    state_d = SUM;
      SUM:     state_d = (den_c == '0) ? DONE : DIV;
      DIV:     if (cnt_q == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rain_q    <= '0;
      soil_q    <= '0;
      rain_lo_q <= '0;
      rain_md_q <= '0;
      rain_hi_q <= '0;
      soil_lo_q <= '0;
      soil_md_q <= '0;
      soil_hi_q <= '0;
      s_lo_q    <= '0;
      s_md_q    <= '0;
      s_hi_q    <= '0;
      quo_q     <= '0;
      den_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      risk_q    <= '0;
      no_fire_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            rain_q <= rain;
            soil_q <= soil;
          end
        end
        FUZZ: begin
          rain_lo_q <= grade(rain_q, C_LO);
          rain_md_q <= grade(rain_q, C_MD);
          rain_hi_q <= grade(rain_q, C_HI);
          soil_lo_q <= grade(soil_q, C_LO);
          soil_md_q <= grade(soil_q, C_MD);
          soil_hi_q <= grade(soil_q, C_HI);
        end
        RULE: begin
          s_lo_q <= min2(rain_lo_q, soil_lo_q);
          s_md_q <= min2(rain_md_q, soil_md_q);
          s_hi_q <= min2(rain_hi_q, soil_hi_q);
        end
        SUM: begin
          quo_q <= num_c;
          den_q <= den_c;
          rem_q <= '0;
          cnt_q <= CW'(NUMW - 1);
          if (den_c == '0) begin
            risk_q    <= '0;
            no_fire_q <= 1'b1;
          end else begin
            no_fire_q <= 1'b0;
          end
        end
        DIV: begin
          quo_q <= quo_n;
          rem_q <= rem_n;
          cnt_q <= cnt_q - CW'(1);
          // Quotient never exceeds the largest OUT_* level, so the low OW bits are exact.
          if (cnt_q == '0) risk_q <= quo_n[OW-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fuzzy_risk_seq.sv
// Directed bench for fuzzy_risk_seq: table of samples with hand-computed risk and latency, plus reset/enable sequences.
module tb_fuzzy_risk_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] rain = '0;
  logic [7:0] soil = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] risk;
  logic       no_fire;
  logic       busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fuzzy_risk_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rain     (rain),
    .soil     (soil),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .risk     (risk),
    .no_fire  (no_fire),
    .busy     (busy)
  );

  typedef struct {
    int rain;
    int soil;
    int risk;
    int nf;
    int lat;
    int hold;
    int en_drop;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Accept one sample, measure edges until out_valid, check result, optionally stall, then handshake.
  task automatic run(input vec_t v);
    int lat;
    int held_ok;
    int wait_n;
    wait_n = 0;
    @(negedge clk);
    while (!in_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    chk("in_ready_before_accept", int'(in_ready), 1);
    rain = 8'(v.rain);
    soil = 8'(v.soil);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (v.en_drop != 0 && lat == v.en_drop) en = 1'b0;
    end
    chk("latency", lat, v.lat);
    chk("risk", int'(risk), v.risk);
    chk("no_fire", int'(no_fire), v.nf);
    held_ok = 1;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      if (!out_valid || int'(risk) != v.risk || in_ready) held_ok = 0;
    end
    if (v.hold > 0) chk("hold_stable", held_ok, 1);
    en = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_hs", int'(out_valid), 0);
    chk("in_ready_after_hs", int'(in_ready), 1);
  endtask

  initial begin
    int saw;
    vec_t v;
    //        rain soil risk nf lat hold en_drop
    vecs[0] = '{80,  80, 255, 0, 21, 0, 0};
    vecs[1] = '{35,  35, 127, 0, 21, 0, 0};
    vecs[2] = '{65,  65, 212, 0, 21, 0, 0};
    vecs[3] = '{20,  80,   0, 1,  3, 0, 0};
    vecs[4] = '{50,  50, 170, 0, 21, 10, 0};
    vecs[5] = '{0,   20,   0, 1,  3, 0, 0};
    vecs[6] = '{255, 20,   0, 1,  3, 0, 0};
    vecs[7] = '{35,  35, 127, 0, 21, 0, 8};

    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_risk", int'(risk), 0);
    chk("rst_no_fire", int'(no_fire), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 8; i++) run(vecs[i]);

    // Disabled block must ignore a valid sample.
    en = 1'b0;
    in_valid = 1'b1;
    rain = 8'd80;
    soil = 8'd80;
    saw = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy || in_ready) saw = 1;
    end
    chk("en0_no_accept", saw, 0);
    in_valid = 1'b0;
    en = 1'b1;

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    rain = 8'd80;
    soil = 8'd80;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_mid_div", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_risk", int'(risk), 0);
    chk("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid || busy) saw = 1;
    end
    chk("no_stale_result", saw, 0);
    v = '{65, 65, 212, 0, 21, 0, 0};
    run(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fuzzy_risk_seq.md
Name: fuzzy_risk_seq

Overview:
- Parametrised successor to the existing 3-rule rainfall/soil-moisture fuzzy risk estimator.
- Accepts one (rain, soil) sample per valid/ready handshake and fuzzifies it with parametrised triangular sets.
- Fires rules using a true min() AND, then defuzzifies by weighted average through a multi-cycle restoring divider.
- Sits between the sensor sampling front end and the alarm/threshold logic, with backpressure on both sides.

Parameters:
- W, 8, input sample width (rain, soil).
- GW, 8, membership grade width; GMAX = 2^GW-1.
- OW, 8, risk output width.
- C_LO, 20, centre of LOW set.
- C_MD, 50, centre of MEDIUM set.
- C_HI, 80, centre of HIGH set.
- HW, 20, half-width of every set. Constraints: C_LO >= HW, C_HI+HW < 2^W, HW > 0.
- OUT_LO, 85, crisp risk level for the LOW rule.
- OUT_MD, 170, crisp risk level for the MEDIUM rule.
- OUT_HI, 255, crisp risk level for the HIGH rule. All OUT_* < 2^OW.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  block enable; gates acceptance only
- in_valid  in  1  sample valid
- in_ready  out  1  block can accept a sample
- rain  in  W  rainfall sample
- soil  in  W  soil-moisture sample
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- risk  out  OW  defuzzified risk
- no_fire  out  1  with out_valid: no rule fired (denominator 0)
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, risk=0, no_fire=0, busy=0. All internal registers cleared. An in-flight transaction is discarded with no output.
- in_ready = en && state==IDLE. Accept on an edge with in_valid && in_ready.
- en=0 never aborts a transaction already in progress.
- FSM states: IDLE, FUZZ, RULE, SUM, DIV, DONE. Each non-DIV state lasts exactly 1 cycle.
- IDLE -> FUZZ on accept; rain/soil are captured on that edge (edge k).
- FUZZ: register 6 grades. Grade for value x, set centre C:
  - a = C-HW, c = C+HW.
  - x <= a or x >= c: 0.
  - a < x <= C: floor((x-a)*GMAX/HW).
  - C < x < c: floor((c-x)*GMAX/HW).
  - x = C gives GMAX.
  - Compare before subtracting; no wrap-around.
- RULE: register three firing strengths:
  - s_hi = min(rain_hi, soil_hi)
  - s_md = min(rain_md, soil_md)
  - s_lo = min(rain_lo, soil_lo)
- SUM: compute
  - num = s_hi*OUT_HI + s_md*OUT_MD + s_lo*OUT_LO, width NUMW = GW+OW+2.
  - den = s_hi + s_md + s_lo, width GW+2.
  - If den==0: go to DONE with risk=0, no_fire=1.
  - Else: go to DIV with no_fire=0.
- DIV: restoring division, one numerator bit per cycle, NUMW cycles, then DONE.
  - risk = floor(num/den), which fits OW bits because the quotient <= max(OUT_*).
- Latency from accept edge k:
  - out_valid rises after edge k+3+NUMW (k+21 with defaults).
  - On the no-fire path, out_valid rises after edge k+3.
- DONE: out_valid=1; risk and no_fire held stable while out_ready=0.
  - On out_valid && out_ready: state goes to IDLE, out_valid drops.
  - The next accept is possible one cycle later, earliest the cycle after the handshake.
- out_ready is ignored outside DONE. in_valid is ignored when in_ready=0.
- risk keeps its last value after the handshake; it is meaningful only while out_valid=1.

Test Plan:
- Reset, then rain=80, soil=80 -> s_hi=255, others 0; out_valid exactly 21 cycles after accept; risk=255, no_fire=0.
- rain=35, soil=35 -> lo grade 63, md grade 63, s_lo=s_md=63; num=16065, den=126 -> risk=127. Then rain=65, soil=65 -> risk=212.
- rain=20, soil=80 -> den=0; out_valid 3 cycles after accept with risk=0, no_fire=1.
- rain=50, soil=50 with out_ready held 0 for 10 cycles -> risk=170 held stable; in_ready=0 throughout DONE; handshake returns to IDLE, in_ready=1 next cycle.
- rain=0 and rain=255 boundaries (soil=20) -> all grades 0 for rain=0, no_fire=1; rain=255 gives no wrap and no_fire=1. en=0 with in_valid=1 -> no accept; en dropped mid-DIV -> transaction still completes.
- Assert rst_n=0 asynchronously mid-DIV -> out_valid, risk, busy go to 0 immediately; no stale result after release; a fresh sample completes normally.
